// File: rtl/smac_seq_ctrl.sv
// Serial-MAC sequencer: walks chunk x channel x weight-plane x activation-bit
// slots, issues reads and skewed datapath strobes, then steps the ReLU output mux.
module smac_seq_ctrl #(
  parameter int M   = 16,
  parameter int Pa  = 8,
  parameter int Pw  = 4,
  parameter int MNO = 288,
  parameter int CW  = $clog2(MNO/M) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CW-1:0]         n_chunks,
  output logic                  busy,
  output logic                  done,
  output logic [CW-1:0]         chunk_idx,
  output logic                  wei_rd,
  output logic [1:0]            wei_ch,
  output logic [$clog2(Pw)-1:0] wei_bit,
  output logic                  act_rd,
  output logic [$clog2(Pa)-1:0] act_bit,
  output logic                  cl_en_gen,
  output logic                  w_en_w,
  output logic                  w_en_br,
  output logic                  MSB_a,
  output logic                  w_and_s_ac1,
  output logic                  cl_en_ac1,
  output logic                  MSB_w,
  output logic                  w_en_neg,
  output logic                  valid_ac2,
  output logic                  cl_en_ac2,
  output logic                  valid_ac3,
  output logic                  cl_en_ac3,
  output logic                  s_en_ac3,
  output logic [1:0]            sel_ac2,
  output logic [1:0]            sel_ac3,
  output logic [1:0]            sel_mux_relu,
  output logic                  out_valid,
  output logic [1:0]            out_ch
);

  localparam int MAXCH = MNO / M;
  localparam int PWB   = $clog2(Pw);
  localparam int PAB   = $clog2(Pa);
  localparam int CNTW  = ($clog2(Pa + 1) > 3) ? $clog2(Pa + 1) : 3;

  localparam logic [CW-1:0]   MAXCH_C    = CW'(MAXCH);
  localparam logic [PWB-1:0]  JLAST      = PWB'(Pw - 1);
  localparam logic [CNTW-1:0] PA_C       = CNTW'(Pa);
  localparam logic [CNTW-1:0] CNT_ONE    = CNTW'(1);
  localparam logic [CNTW-1:0] DRAIN_LAST = CNTW'(4);
  localparam logic [CNTW-1:0] OUT_LAST   = CNTW'(3);

  typedef enum logic [2:0] {IDLE, LOADW, STREAM, DRAIN, OUTPUT, FIN} state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [PWB-1:0]  j_q, j_d;
  logic [1:0]      k_q, k_d;
  logic [CW-1:0]   c_q, c_d;
  logic [CW-1:0]   nch_q, nch_d;

  // Strobe pipeline: stage 1 = AC1 (T+s+1), 2 = neg, 3 = AC2, 4 = AC3.
  logic       v1_q, first1_q, last1_q, lj1_q, c01_q;
  logic [1:0] k1_q;
  logic       neg_q, lj2_q, c02_q;
  logic [1:0] k2_q;
  logic       ac2_q, lj3_q, c03_q;
  logic [1:0] k3_q;
  logic       ac3_q, sen4_q;
  logic [1:0] k4_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      c_q     <= '0;
      nch_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      c_q     <= c_d;
      nch_q   <= nch_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    j_d          = j_q;
    k_d          = k_q;
    c_d          = c_q;
    nch_d        = nch_q;
    done         = 1'b0;
    wei_rd       = 1'b0;
    w_en_w       = 1'b0;
    wei_ch       = '0;
    wei_bit      = '0;
    act_rd       = 1'b0;
    act_bit      = '0;
    w_en_br      = 1'b0;
    MSB_a        = 1'b0;
    out_valid    = 1'b0;
    out_ch       = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (n_chunks == '0) begin
            state_d = FIN;
          end else begin
            nch_d   = (n_chunks > MAXCH_C) ? MAXCH_C : n_chunks;
            cnt_d   = '0;
            j_d     = '0;
            k_d     = '0;
            c_d     = '0;
            state_d = LOADW;
          end
        end
      end
      LOADW: begin
        wei_rd  = 1'b1;
        w_en_w  = 1'b1;
        wei_ch  = k_q;
        wei_bit = j_q;
        cnt_d   = CNT_ONE;
        state_d = STREAM;
      end
      STREAM: begin
        act_rd  = 1'b1;
        w_en_br = 1'b1;
        act_bit = PAB'(PA_C - cnt_q);
        MSB_a   = (cnt_q == CNT_ONE);
        if (cnt_q == PA_C) begin
          cnt_d   = '0;
          state_d = LOADW;
          if (j_q != JLAST) begin
            j_d = j_q + 1'b1;
          end else begin
            j_d = '0;
            if (k_q != 2'd3) begin
              k_d = k_q + 1'b1;
            end else begin
              k_d = '0;
              // Chunk index holds through DRAIN; it wraps only on leaving it.
              if (c_q == nch_q - 1'b1) state_d = DRAIN;
              else                     c_d     = c_q + 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          c_d     = '0;
          state_d = OUTPUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      OUTPUT: begin
        out_valid = 1'b1;
        out_ch    = cnt_q[1:0];
        if (cnt_q == OUT_LAST) begin
          cnt_d   = '0;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0; first1_q <= 1'b0; last1_q <= 1'b0; lj1_q <= 1'b0; c01_q <= 1'b0; k1_q <= '0;
      neg_q <= 1'b0; lj2_q <= 1'b0; c02_q <= 1'b0; k2_q <= '0;
      ac2_q <= 1'b0; lj3_q <= 1'b0; c03_q <= 1'b0; k3_q <= '0;
      ac3_q <= 1'b0; sen4_q <= 1'b0; k4_q <= '0;
    end else begin
      v1_q     <= (state_q == STREAM);
      first1_q <= (cnt_q == CNT_ONE);
      last1_q  <= (cnt_q == PA_C);
      lj1_q    <= (j_q == JLAST);
      c01_q    <= (c_q == '0);
      k1_q     <= k_q;
      neg_q    <= v1_q & last1_q;
      lj2_q    <= lj1_q;
      c02_q    <= c01_q;
      k2_q     <= k1_q;
      ac2_q    <= neg_q;
      lj3_q    <= lj2_q;
      c03_q    <= c02_q;
      k3_q     <= k2_q;
      ac3_q    <= ac2_q & lj3_q;
      sen4_q   <= c03_q;
      k4_q     <= k3_q;
    end
  end

  assign busy         = (state_q != IDLE);
  assign cl_en_gen    = busy;
  assign chunk_idx    = c_q;
  assign sel_mux_relu = out_ch;
  assign cl_en_ac1    = v1_q;
  assign w_and_s_ac1  = v1_q & ~first1_q;
  assign w_en_neg     = neg_q;
  assign MSB_w        = neg_q & lj2_q;
  assign valid_ac2    = ac2_q;
  assign cl_en_ac2    = ac2_q;
  assign sel_ac2      = ac2_q ? k3_q : 2'd0;
  assign valid_ac3    = ac3_q;
  assign cl_en_ac3    = ac3_q;
  assign sel_ac3      = ac3_q ? k4_q : 2'd0;
  assign s_en_ac3     = ac3_q & sen4_q;

endmodule

// File: tb/tb_smac_seq_ctrl.sv
// Directed bench for smac_seq_ctrl: strobe counts, per-slot skew, clamping,
// reset abort and start filtering.
module tb_smac_seq_ctrl;
  localparam int CW = 6;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [CW-1:0] n_chunks = '0;
  logic          busy, done, wei_rd, act_rd, cl_en_gen, w_en_w, w_en_br, MSB_a;
  logic          w_and_s_ac1, cl_en_ac1, MSB_w, w_en_neg, valid_ac2, cl_en_ac2;
  logic          valid_ac3, cl_en_ac3, s_en_ac3, out_valid;
  logic [CW-1:0] chunk_idx;
  logic [1:0]    wei_ch, wei_bit, sel_ac2, sel_ac3, sel_mux_relu, out_ch;
  logic [2:0]    act_bit;

  smac_seq_ctrl #(.M(16), .Pa(8), .Pw(4), .MNO(288)) dut (
    .clk(clk), .rst(rst), .start(start), .n_chunks(n_chunks),
    .busy(busy), .done(done), .chunk_idx(chunk_idx),
    .wei_rd(wei_rd), .wei_ch(wei_ch), .wei_bit(wei_bit),
    .act_rd(act_rd), .act_bit(act_bit),
    .cl_en_gen(cl_en_gen), .w_en_w(w_en_w), .w_en_br(w_en_br), .MSB_a(MSB_a),
    .w_and_s_ac1(w_and_s_ac1), .cl_en_ac1(cl_en_ac1), .MSB_w(MSB_w),
    .w_en_neg(w_en_neg), .valid_ac2(valid_ac2), .cl_en_ac2(cl_en_ac2),
    .valid_ac3(valid_ac3), .cl_en_ac3(cl_en_ac3), .s_en_ac3(s_en_ac3),
    .sel_ac2(sel_ac2), .sel_ac3(sel_ac3), .sel_mux_relu(sel_mux_relu),
    .out_valid(out_valid), .out_ch(out_ch)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  bit mon_on = 1'b0;
  int n_issue, n_w, n_br, n_neg, n_ac2, n_ac3, n_sen, n_out;
  int out_first, out_last, skew_err, max_chunk, done_cyc;
  logic [15:0] wenw_hist;
  logic [1:0]  msbw_hist;
  logic [1:0]  bit_hist [16];
  logic [1:0]  ch_hist  [16];
  logic        p_act_rd, p_msba, p_neg;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({busy, done, chunk_idx, wei_rd, wei_ch, wei_bit, act_rd, act_bit,
                cl_en_gen, w_en_w, w_en_br, MSB_a, w_and_s_ac1, cl_en_ac1, MSB_w,
                w_en_neg, valid_ac2, cl_en_ac2, valid_ac3, cl_en_ac3, s_en_ac3,
                sel_ac2, sel_ac3, sel_mux_relu, out_valid, out_ch});
  endfunction

  task tick();
    @(posedge clk);
    #1;
    cyc++;
    if (mon_on) begin
      if (wei_rd || act_rd) n_issue++;
      if (w_en_w) begin
        if (int'(chunk_idx) != n_w / 16 || int'(wei_ch) != (n_w / 4) % 4 ||
            int'(wei_bit) != n_w % 4) skew_err++;
        if (int'(chunk_idx) > max_chunk) max_chunk = int'(chunk_idx);
        n_w++;
      end
      if (w_en_br) n_br++;
      if (w_en_br !== act_rd) skew_err++;
      if (MSB_a !== (act_rd && act_bit == 3'd7)) skew_err++;
      if (cl_en_ac1 !== p_act_rd) skew_err++;
      if (w_and_s_ac1 !== (cl_en_ac1 && !p_msba)) skew_err++;
      if (w_en_neg !== wenw_hist[9]) skew_err++;
      if (MSB_w !== (wenw_hist[9] && bit_hist[9] == 2'd3)) skew_err++;
      if (w_en_neg) n_neg++;
      if (valid_ac2 !== p_neg || cl_en_ac2 !== valid_ac2) skew_err++;
      if (valid_ac2 && sel_ac2 !== ch_hist[10]) skew_err++;
      if (valid_ac2) n_ac2++;
      if (valid_ac3 !== msbw_hist[1] || cl_en_ac3 !== valid_ac3) skew_err++;
      if (valid_ac3 && sel_ac3 !== ch_hist[11]) skew_err++;
      if (s_en_ac3 !== (valid_ac3 && n_ac3 < 4)) skew_err++;
      if (s_en_ac3) n_sen++;
      if (valid_ac3) n_ac3++;
      if (out_valid) begin
        if (int'(out_ch) != n_out || sel_mux_relu !== out_ch || chunk_idx != '0) skew_err++;
        if (out_first < 0) out_first = cyc;
        out_last = cyc;
        n_out++;
      end
      if (busy !== 1'b1 || cl_en_gen !== busy) skew_err++;
    end
    p_act_rd  = act_rd;
    p_msba    = MSB_a;
    p_neg     = w_en_neg;
    msbw_hist = {msbw_hist[0], MSB_w};
    wenw_hist = {wenw_hist[14:0], w_en_w};
    for (int i = 15; i > 0; i--) begin
      bit_hist[i] = bit_hist[i-1];
      ch_hist[i]  = ch_hist[i-1];
    end
    bit_hist[0] = wei_bit;
    ch_hist[0]  = wei_ch;
  endtask

  // nch: value driven; ch: effective chunk count after clamping.
  task run(input int nch, input int ch, input int pulse_at, input bit pulse_on_done);
    n_issue = 0; n_w = 0; n_br = 0; n_neg = 0; n_ac2 = 0; n_ac3 = 0; n_sen = 0; n_out = 0;
    out_first = -1; out_last = -1; skew_err = 0; max_chunk = 0; done_cyc = -1;
    wenw_hist = '0; msbw_hist = '0; p_act_rd = 1'b0; p_msba = 1'b0; p_neg = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bit_hist[i] = '0;
      ch_hist[i]  = '0;
    end
    n_chunks = CW'(nch);
    start    = 1'b1;
    cyc      = 0;
    mon_on   = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      tick();
      start = (cyc == pulse_at);
      if (cyc == pulse_at) n_chunks = 6'd2;
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    mon_on = 1'b0;
    start  = pulse_on_done;
    tick();
    start  = 1'b0;
    chk($sformatf("n%0d idle busy", nch), busy, 0);
    chk($sformatf("n%0d done width", nch), done, 0);
    chk($sformatf("n%0d done cycle", nch), done_cyc, (ch == 0) ? 1 : ch * 144 + 10);
    chk($sformatf("n%0d issue cycles", nch), n_issue, ch * 144);
    chk($sformatf("n%0d w_en_w", nch), n_w, ch * 16);
    chk($sformatf("n%0d w_en_br", nch), n_br, ch * 128);
    chk($sformatf("n%0d w_en_neg", nch), n_neg, ch * 16);
    chk($sformatf("n%0d valid_ac2", nch), n_ac2, ch * 16);
    chk($sformatf("n%0d valid_ac3", nch), n_ac3, ch * 4);
    chk($sformatf("n%0d s_en_ac3", nch), n_sen, (ch == 0) ? 0 : 4);
    chk($sformatf("n%0d out count", nch), n_out, (ch == 0) ? 0 : 4);
    chk($sformatf("n%0d out first", nch), out_first, (ch == 0) ? -1 : ch * 144 + 6);
    chk($sformatf("n%0d out last", nch), out_last, (ch == 0) ? -1 : ch * 144 + 9);
    chk($sformatf("n%0d max chunk", nch), max_chunk, (ch == 0) ? 0 : ch - 1);
    chk($sformatf("n%0d skew errors", nch), skew_err, 0);
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    chk("reset outputs", all_outs(), 0);
    rst = 1'b0;
    tick();
    chk("idle after reset", busy, 0);

    run(1, 1, -1, 1'b0);
    run(3, 3, -1, 1'b0);
    run(0, 0, -1, 1'b0);
    run(31, 18, -1, 1'b0);

    // Abort in the middle of streaming, then a clean rerun.
    n_chunks = 6'd1;
    start = 1'b1;
    cyc = 0;
    tick();
    start = 1'b0;
    repeat (19) tick();
    chk("midrst streaming", act_rd, 1);
    rst = 1'b1;
    #1;
    chk("midrst async outs", all_outs(), 0);
    tick();
    chk("midrst next outs", all_outs(), 0);
    rst = 1'b0;
    tick();
    chk("midrst idle", busy, 0);
    run(1, 1, -1, 1'b0);

    // Start pulsed while busy and on the done cycle, then back-to-back.
    run(1, 1, 50, 1'b1);
    run(1, 1, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
